// File: rtl/spi_pktfifo.sv
// Packet elastic buffer ahead of the SPI top's emesh input: access/packet/wait in, access/packet/wait out.
// Optional sticky push-while-full flag is built only when SPI_PKTFIFO_OVERFLOW_EN is defined.
module spi_pktfifo #(
  parameter int AW    = 32,
  parameter int PW    = 104,
  parameter int DEPTH = 4,
  parameter int AFULL = 3
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     access_in,
  input  logic [PW-1:0]            packet_in,
  output logic                     wait_out,
  output logic                     access_out,
  output logic [PW-1:0]            packet_out,
  input  logic                     wait_in,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     prog_full,
  output logic                     empty,
  output logic                     overflow
);

  localparam int AB   = $clog2(DEPTH);
  localparam int PTRW = AB + 1;

  if (AW < 1) begin : g_bad_aw
    $error("spi_pktfifo: AW must be positive");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("spi_pktfifo: DEPTH must be a power of two >= 2");
  end
  if (AFULL < 1 || AFULL > DEPTH) begin : g_bad_afull
    $error("spi_pktfifo: AFULL must be in 1..DEPTH");
  end

  logic [PW-1:0]   mem_q [DEPTH];
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTRW-1:0] count_q, count_d;
  logic            full;
  logic            push;
  logic            pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full  = (wr_ptr_q[AB] != rd_ptr_q[AB]) && (wr_ptr_q[AB-1:0] == rd_ptr_q[AB-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign push = access_in && !full;
  assign pop  = !empty && !wait_in;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AB{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AB{1'b0}}, pop};
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AB-1:0]] <= packet_in;
    end
  end

  assign access_out = !empty;
  assign packet_out = mem_q[rd_ptr_q[AB-1:0]];
  assign wait_out   = full;
  assign count      = count_q;
  assign prog_full  = (count_q >= PTRW'(AFULL));

`ifdef SPI_PKTFIFO_OVERFLOW_EN
  logic overflow_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      overflow_q <= 1'b0;
    end else if (access_in && full) begin
      overflow_q <= 1'b1;
    end
  end

  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

endmodule
